// File: rtl/mac_pe_if.sv
// Bundle of weight-chain, control and datapath signals for one mac_pe cell.
// The master side drives weights/activations/control; the slave side is the PE.
interface mac_pe_if #(
  parameter int DATA_W    = 8,
  parameter int WEIGHT_W  = 8,
  parameter int ACC_W     = 32,
  parameter int NUM_BANKS = 2
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic                load_weight;
  logic [WEIGHT_W-1:0] weight_in;
  logic [WEIGHT_W-1:0] weight_out;
  logic                swap_weights;
  logic [BANK_W-1:0]   swap_bank;
  logic [BANK_W-1:0]   bank_sel;
  logic                signed_mode;
  logic                run;
  logic [DATA_W-1:0]   data_in;
  logic [ACC_W-1:0]    acc_in;
  logic                run_out;
  logic [DATA_W-1:0]   data_out;
  logic                acc_valid_out;
  logic [ACC_W-1:0]    acc_out;
  logic                sat_out;

  modport master (
    output load_weight, weight_in, swap_weights, swap_bank, bank_sel,
           signed_mode, run, data_in, acc_in,
    input  weight_out, run_out, data_out, acc_valid_out, acc_out, sat_out
  );

  modport slave (
    input  load_weight, weight_in, swap_weights, swap_bank, bank_sel,
           signed_mode, run, data_in, acc_in,
    output weight_out, run_out, data_out, acc_valid_out, acc_out, sat_out
  );
endinterface

// File: rtl/mac_pe.sv
// mac_pe: banked-weight MAC cell; data_out at +1 cycle, acc_out at +2, one beat/cycle, no backpressure.
// Define MAC_PE_SATURATE_EN to clamp the stage-2 sum and flag sat_out; otherwise the sum wraps.
module mac_pe #(
  parameter int DATA_W    = 8,
  parameter int WEIGHT_W  = 8,
  parameter int ACC_W     = 32,
  parameter int NUM_BANKS = 2
) (
  input  logic   clk,
  input  logic   rst,
  mac_pe_if.slave pe
);
  localparam int PROD_W = DATA_W + WEIGHT_W;

  logic [WEIGHT_W-1:0] shadow_q, shadow_d;
  logic [WEIGHT_W-1:0] bank_q [NUM_BANKS];
  logic [WEIGHT_W-1:0] bank_d [NUM_BANKS];
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                run_out_q, run_out_d;
  logic [PROD_W-1:0]   p_q, p_d;
  logic [ACC_W-1:0]    a1_q, a1_d;
  logic                m1_q, m1_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                acc_vld_q, acc_vld_d;
  logic                sat_q, sat_d;

  logic [WEIGHT_W-1:0] commit_w;
  logic [WEIGHT_W-1:0] w_sel;
  logic [PROD_W-1:0]   a_full, w_full;
  logic [ACC_W-1:0]    p_ext;

  // Weight chain and bank commit; an incoming weight wins over the old shadow.
  always_comb begin
    shadow_d = shadow_q;
    bank_d   = bank_q;
    commit_w = pe.load_weight ? pe.weight_in : shadow_q;
    if (pe.load_weight) shadow_d = pe.weight_in;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (pe.swap_weights && (32'(pe.swap_bank) == i)) bank_d[i] = commit_w;
    end
  end

  // Out-of-range bank_sel falls through to bank 0.
  always_comb begin
    w_sel = bank_q[0];
    for (int i = 1; i < NUM_BANKS; i++) begin
      if (32'(pe.bank_sel) == i) w_sel = bank_q[i];
    end
  end

  // Stage 1: product truncated to PROD_W bits is exact for both signed and unsigned operands.
  always_comb begin
    a_full     = {{WEIGHT_W{pe.signed_mode & pe.data_in[DATA_W-1]}}, pe.data_in};
    w_full     = {{DATA_W{pe.signed_mode & w_sel[WEIGHT_W-1]}}, w_sel};
    p_d        = p_q;
    a1_d       = a1_q;
    m1_d       = m1_q;
    data_out_d = data_out_q;
    run_out_d  = pe.run;
    if (pe.run) begin
      p_d        = a_full * w_full;
      a1_d       = pe.acc_in;
      m1_d       = pe.signed_mode;
      data_out_d = pe.data_in;
    end
  end

  assign p_ext = {{(ACC_W-PROD_W){m1_q & p_q[PROD_W-1]}}, p_q};

`ifdef MAC_PE_SATURATE_EN
  logic [ACC_W:0] sum;

  // One extra bit exposes signed overflow (top two bits differ) or unsigned carry-out.
  always_comb begin
    sum       = {m1_q & a1_q[ACC_W-1], a1_q} + {m1_q & p_ext[ACC_W-1], p_ext};
    acc_d     = acc_q;
    sat_d     = sat_q;
    acc_vld_d = run_out_q;
    if (run_out_q) begin
      acc_d = sum[ACC_W-1:0];
      sat_d = 1'b0;
      if (m1_q && (sum[ACC_W] != sum[ACC_W-1])) begin
        acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        sat_d = 1'b1;
      end else if (!m1_q && sum[ACC_W]) begin
        acc_d = {ACC_W{1'b1}};
        sat_d = 1'b1;
      end
    end
  end
`else
  always_comb begin
    acc_d     = acc_q;
    sat_d     = 1'b0;
    acc_vld_d = run_out_q;
    if (run_out_q) acc_d = a1_q + p_ext;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= '0;
      for (int i = 0; i < NUM_BANKS; i++) bank_q[i] <= '0;
      data_out_q <= '0;
      run_out_q  <= 1'b0;
      p_q        <= '0;
      a1_q       <= '0;
      m1_q       <= 1'b0;
      acc_q      <= '0;
      acc_vld_q  <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      bank_q     <= bank_d;
      data_out_q <= data_out_d;
      run_out_q  <= run_out_d;
      p_q        <= p_d;
      a1_q       <= a1_d;
      m1_q       <= m1_d;
      acc_q      <= acc_d;
      acc_vld_q  <= acc_vld_d;
      sat_q      <= sat_d;
    end
  end

  assign pe.weight_out    = shadow_q;
  assign pe.run_out       = run_out_q;
  assign pe.data_out      = data_out_q;
  assign pe.acc_valid_out = acc_vld_q;
  assign pe.acc_out       = acc_q;
  assign pe.sat_out       = sat_q;
endmodule
